// File: rtl/pipe_pwr_pkg.sv
// rtl/pipe_pwr_pkg.sv - shared types and constants for the PIPE power/receiver-detect sequencer
package pipe_pwr_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    PWR_WAIT = 2'd2,
    DET_WAIT = 2'd3
  } pwr_fsm_e;

  localparam logic [1:0] P0 = 2'b00;
  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] P2 = 2'b10;
  localparam logic [1:0] P3 = 2'b11;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_REJECT  = 2'b10;

  localparam logic REQ_POWER  = 1'b0;
  localparam logic REQ_DETECT = 1'b1;

  localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

endpackage

// File: rtl/pipe_pwr_timer.sv
// rtl/pipe_pwr_timer.sv - completion-timeout counter for the PIPE sequencer wait states
module pipe_pwr_timer #(
  parameter int           W        = 16,
  parameter logic [W-1:0] TERMINAL = 16'd10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [W-1:0] LAST = TERMINAL - W'(1);

  logic [W-1:0] count;

  // Holds at the terminal value so tc stays asserted until the caller clears it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/pipe_power_ctrl.sv
// rtl/pipe_power_ctrl.sv - PIPE PowerDown / TxDetectRx sequencer; timeout built only with PIPE_PWR_TIMEOUT_EN
module pipe_power_ctrl
  import pipe_pwr_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd10000
) (
  input  logic       phy_pipe_pclk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_type,
  input  logic [1:0] req_state,
  output logic       req_ready,
  output logic       done,
  output logic [1:0] done_status,
  output logic       rx_present,
  output logic [1:0] cur_power_state,
  output logic       busy,
  output logic       spurious_status,
  output logic [1:0] phy_power_down,
  output logic       phy_tx_detrx_lpbk,
  input  logic       phy_phy_status,
  input  logic [2:0] phy_rx_status
);

  pwr_fsm_e   state, state_nxt;
  logic [1:0] power_down_nxt;
  logic       detrx_nxt;
  logic [1:0] cur_state_nxt;
  logic       rx_present_nxt;
  logic       done_nxt;
  logic [1:0] done_status_nxt;
  logic       spurious_nxt;
  logic       tmo_hit;

`ifdef PIPE_PWR_TIMEOUT_EN
  logic in_wait;
  assign in_wait = (state == PWR_WAIT) || (state == DET_WAIT);

  pipe_pwr_timer #(
    .W        (TIMEOUT_W),
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (phy_pipe_pclk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .tc     (tmo_hit)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge phy_pipe_pclk) begin
    if (reset) begin
      state             <= INIT;
      phy_power_down    <= P2;
      phy_tx_detrx_lpbk <= 1'b0;
      cur_power_state   <= P2;
      rx_present        <= 1'b0;
      done              <= 1'b0;
      done_status       <= STAT_OK;
      spurious_status   <= 1'b0;
    end else begin
      state             <= state_nxt;
      phy_power_down    <= power_down_nxt;
      phy_tx_detrx_lpbk <= detrx_nxt;
      cur_power_state   <= cur_state_nxt;
      rx_present        <= rx_present_nxt;
      done              <= done_nxt;
      done_status       <= done_status_nxt;
      spurious_status   <= spurious_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    power_down_nxt  = phy_power_down;
    detrx_nxt       = phy_tx_detrx_lpbk;
    cur_state_nxt   = cur_power_state;
    rx_present_nxt  = rx_present;
    done_nxt        = 1'b0;
    done_status_nxt = done_status;
    spurious_nxt    = spurious_status;

    unique case (state)
      INIT: begin
        // PhyStatus low after reset means PCLK from the PHY is stable.
        if (!phy_phy_status) begin
          state_nxt = IDLE;
        end
      end

      IDLE: begin
        if (phy_phy_status) begin
          spurious_nxt = 1'b1;
        end
        if (req_valid) begin
          if (req_type == REQ_POWER) begin
            if (req_state == cur_power_state) begin
              done_nxt        = 1'b1;
              done_status_nxt = STAT_OK;
            end else begin
              power_down_nxt = req_state;
              state_nxt      = PWR_WAIT;
            end
          end else if (cur_power_state != P3) begin
            done_nxt        = 1'b1;
            done_status_nxt = STAT_REJECT;
          end else begin
            detrx_nxt = 1'b1;
            state_nxt = DET_WAIT;
          end
        end
      end

      PWR_WAIT: begin
        // A status pulse coinciding with the terminal count still counts as success.
        if (phy_phy_status) begin
          cur_state_nxt   = phy_power_down;
          done_nxt        = 1'b1;
          done_status_nxt = STAT_OK;
          state_nxt       = IDLE;
        end else if (tmo_hit) begin
          power_down_nxt  = cur_power_state;
          done_nxt        = 1'b1;
          done_status_nxt = STAT_TIMEOUT;
          state_nxt       = IDLE;
        end
      end

      DET_WAIT: begin
        if (phy_phy_status) begin
          rx_present_nxt  = (phy_rx_status == RXSTAT_RX_PRESENT);
          detrx_nxt       = 1'b0;
          done_nxt        = 1'b1;
          done_status_nxt = STAT_OK;
          state_nxt       = IDLE;
        end else if (tmo_hit) begin
          rx_present_nxt  = 1'b0;
          detrx_nxt       = 1'b0;
          done_nxt        = 1'b1;
          done_status_nxt = STAT_TIMEOUT;
          state_nxt       = IDLE;
        end
      end

      default: state_nxt = INIT;
    endcase
  end

endmodule
